// File: rtl/mmio_arbiter.sv
// Round-robin two-master to one-slave arbiter for the minisoc MMIO bus, with at most one read outstanding.
// Optional read timeout when MMIO_ARB_TIMEOUT_EN is defined.
module mmio_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            m0_req,
  input  logic            m0_write,
  input  logic [DW/8-1:0] m0_wstrb,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_ready,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_write,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_ready,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            s_req,
  output logic            s_write,
  output logic [DW/8-1:0] s_wstrb,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  input  logic            s_ready,
  input  logic            s_rvalid,
  input  logic [DW-1:0]   s_rdata,
  output logic            err
);

  typedef enum logic {IDLE, WAIT_RSP} state_t;

  if (TO_CYCLES < 1) begin : g_bad_to_cycles
    $error("mmio_arbiter: TO_CYCLES must be >= 1");
  end

  state_t        state;
  logic          last;
  logic          owner;
  logic          hold_valid;
  logic          hold_id;
  logic          gnt;
  logic          accept;
  logic          rd_accept;
  logic          timeout;
  logic          rsp;
  logic [DW-1:0] rsp_data;

  // A stalled grant is remembered so a late-arriving competitor cannot steal it mid-wait.
  always_comb begin
    gnt = 1'b0;
    if (hold_valid && (hold_id ? m1_req : m0_req))
      gnt = hold_id;
    else if (m0_req && m1_req)
      gnt = ~last;
    else if (m1_req)
      gnt = 1'b1;

    s_req     = (state == IDLE) && (m0_req || m1_req);
    s_write   = gnt ? m1_write : m0_write;
    s_wstrb   = gnt ? m1_wstrb : m0_wstrb;
    s_addr    = gnt ? m1_addr  : m0_addr;
    s_wdata   = gnt ? m1_wdata : m0_wdata;
    m0_ready  = s_req && !gnt && s_ready;
    m1_ready  = s_req &&  gnt && s_ready;
    accept    = s_req && s_ready;
    rd_accept = accept && !s_write;

    rsp       = (state == WAIT_RSP) && (s_rvalid || timeout);
    m0_rvalid = rsp && !owner;
    m1_rvalid = rsp &&  owner;
    m0_rdata  = rsp_data;
    m1_rdata  = rsp_data;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      last       <= 1'b1;
      owner      <= 1'b0;
      hold_valid <= 1'b0;
      hold_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last       <= gnt;
            hold_valid <= 1'b0;
            if (!s_write) begin
              owner <= gnt;
              state <= WAIT_RSP;
            end
          end else if (s_req) begin
            hold_valid <= 1'b1;
            hold_id    <= gnt;
          end else begin
            hold_valid <= 1'b0;
          end
        end
        WAIT_RSP: begin
          if (s_rvalid || timeout)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MMIO_ARB_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TO_CYCLES + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;
  localparam logic [DW-1:0] BAD_DATA = DW'(32'hDEADBEEF);

  logic [CW-1:0] to_cnt;

  // Counter reads TO_CYCLES-1 on the TO_CYCLES-th wait cycle, which is when the timeout fires.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      to_cnt <= '0;
    else if (state == IDLE && rd_accept)
      to_cnt <= '0;
    else if (state == WAIT_RSP && !s_rvalid)
      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout  = (state == WAIT_RSP) && !s_rvalid && (to_cnt == CW'(TO_CYCLES - 1));
  assign err      = timeout;
  assign rsp_data = timeout ? BAD_DATA : s_rdata;
`else
  assign timeout  = 1'b0;
  assign err      = 1'b0;
  assign rsp_data = s_rdata;
`endif

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed self-checking bench for mmio_arbiter: grant order, stall hold, read routing, reset abandon,
// and the timeout path when MMIO_ARB_TIMEOUT_EN is defined.
module tb_mmio_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_b;
  logic            m0_req, m0_write, m1_req, m1_write;
  logic [DW/8-1:0] m0_wstrb, m1_wstrb;
  logic [AW-1:0]   m0_addr, m1_addr;
  logic [DW-1:0]   m0_wdata, m1_wdata;
  logic            m0_ready, m0_rvalid, m1_ready, m1_rvalid;
  logic [DW-1:0]   m0_rdata, m1_rdata;
  logic            s_req, s_write;
  logic [DW/8-1:0] s_wstrb;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_ready, s_rvalid;
  logic [DW-1:0]   s_rdata;
  logic            err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_arbiter #(.AW(AW), .DW(DW), .TO_CYCLES(4)) dut (
    .clk(clk), .rst_b(rst_b),
    .m0_req(m0_req), .m0_write(m0_write), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_write(s_write), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .err(err)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_write = 0; m0_wstrb = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_write = 0; m1_wstrb = '0; m1_addr = '0; m1_wdata = '0;
    s_ready = 0; s_rvalid = 0; s_rdata = '0;
  endtask

  initial begin
    rst_b = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    sample();
    check_output("rst_s_req", s_req, 0);
    check_output("rst_m0_ready", m0_ready, 0);
    check_output("rst_m1_ready", m1_ready, 0);
    check_output("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
    check_output("rst_err", err, 0);
    rst_b = 1;

    // single m0 write
    next_cycle();
    m0_req = 1; m0_write = 1; m0_wstrb = 4'hF; m0_addr = 12'h010; m0_wdata = 32'hA5; s_ready = 1;
    sample();
    check_output("w0_s_req", s_req, 1);
    check_output("w0_s_addr", s_addr, 12'h010);
    check_output("w0_s_wdata", s_wdata, 32'hA5);
    check_output("w0_s_write", s_write, 1);
    check_output("w0_m0_ready", m0_ready, 1);
    check_output("w0_m1_ready", m1_ready, 0);
    check_output("w0_rvalid", {m1_rvalid, m0_rvalid}, 0);
    next_cycle();
    idle_inputs();

    // fresh reset so the contention run starts from last = 1
    rst_b = 0;
    next_cycle();
    rst_b = 1;

    m0_req = 1; m0_write = 1; m0_wstrb = 4'hF; m0_addr = 12'h100; m0_wdata = 32'h1;
    m1_req = 1; m1_write = 1; m1_wstrb = 4'h3; m1_addr = 12'h200; m1_wdata = 32'h2;
    s_ready = 1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check_output($sformatf("rr%0d_m0_ready", i), m0_ready, (i % 2 == 0) ? 1 : 0);
      check_output($sformatf("rr%0d_m1_ready", i), m1_ready, (i % 2 == 0) ? 0 : 1);
      check_output($sformatf("rr%0d_s_addr", i), s_addr, (i % 2 == 0) ? 12'h100 : 12'h200);
      next_cycle();
    end
    idle_inputs();

    // m1 read, response three cycles later while m0 waits
    m1_req = 1; m1_write = 0; m1_addr = 12'h004; s_ready = 1;
    sample();
    check_output("rd_m1_ready", m1_ready, 1);
    check_output("rd_s_write", s_write, 0);
    check_output("rd_s_addr", s_addr, 12'h004);
    next_cycle();
    m1_req = 0;
    m0_req = 1; m0_write = 1; m0_wstrb = 4'hF; m0_addr = 12'h020; m0_wdata = 32'h77;
    sample();
    check_output("wait1_s_req", s_req, 0);
    check_output("wait1_m0_ready", m0_ready, 0);
    next_cycle();
    sample();
    check_output("wait2_m0_ready", m0_ready, 0);
    check_output("wait2_m1_rvalid", m1_rvalid, 0);
    next_cycle();
    s_rvalid = 1; s_rdata = 32'h5A;
    sample();
    check_output("rsp_m1_rvalid", m1_rvalid, 1);
    check_output("rsp_m1_rdata", m1_rdata, 32'h5A);
    check_output("rsp_m0_rvalid", m0_rvalid, 0);
    check_output("rsp_m0_rdata", m0_rdata, 32'h5A);
    check_output("rsp_m0_ready", m0_ready, 0);
    next_cycle();
    s_rvalid = 0;
    sample();
    check_output("after_rsp_m0_ready", m0_ready, 1);
    check_output("after_rsp_s_addr", s_addr, 12'h020);
    next_cycle();
    idle_inputs();
    s_rvalid = 1; s_rdata = 32'h33;
    sample();
    check_output("idle_rvalid_ignored", {m1_rvalid, m0_rvalid}, 0);
    next_cycle();
    idle_inputs();

    // stall: m0 granted alone, m1 joins, grant must not move
    m0_req = 1; m0_write = 1; m0_wstrb = 4'hF; m0_addr = 12'h0A0; m0_wdata = 32'hAA;
    sample();
    check_output("stall0_s_req", s_req, 1);
    check_output("stall0_s_addr", s_addr, 12'h0A0);
    check_output("stall0_m0_ready", m0_ready, 0);
    next_cycle();
    m1_req = 1; m1_write = 1; m1_wstrb = 4'hF; m1_addr = 12'h0B0; m1_wdata = 32'hBB;
    for (int i = 1; i < 5; i++) begin
      sample();
      check_output($sformatf("stall%0d_s_addr", i), s_addr, 12'h0A0);
      check_output($sformatf("stall%0d_m1_ready", i), m1_ready, 0);
      next_cycle();
    end
    s_ready = 1;
    sample();
    check_output("stall_release_m0_ready", m0_ready, 1);
    check_output("stall_release_m1_ready", m1_ready, 0);
    next_cycle();
    m0_req = 0;
    sample();
    check_output("stall_next_m1_ready", m1_ready, 1);
    check_output("stall_next_s_addr", s_addr, 12'h0B0);
    next_cycle();
    idle_inputs();

    // reset while a read is outstanding
    m0_req = 1; m0_write = 0; m0_addr = 12'h008; s_ready = 1;
    sample();
    check_output("rstrd_m0_ready", m0_ready, 1);
    next_cycle();
    idle_inputs();
    rst_b = 0;
    sample();
    check_output("rstrd_in_reset_rvalid", {m1_rvalid, m0_rvalid}, 0);
    next_cycle();
    rst_b = 1;
    s_rvalid = 1; s_rdata = 32'h99;
    sample();
    check_output("rstrd_late_rvalid", {m1_rvalid, m0_rvalid}, 0);
    next_cycle();
    s_rvalid = 0;
    m0_req = 1; m0_write = 1; m0_wstrb = 4'hF; m0_addr = 12'h030;
    m1_req = 1; m1_write = 1; m1_wstrb = 4'hF; m1_addr = 12'h040;
    s_ready = 1;
    sample();
    check_output("rstrd_contend_m0_ready", m0_ready, 1);
    check_output("rstrd_contend_m1_ready", m1_ready, 0);
    check_output("rstrd_err", err, 0);
    next_cycle();
    idle_inputs();

`ifdef MMIO_ARB_TIMEOUT_EN
    // read with no response: timeout on the fourth wait cycle
    m0_req = 1; m0_write = 0; m0_addr = 12'h00C; s_ready = 1;
    sample();
    check_output("to_accept", m0_ready, 1);
    next_cycle();
    idle_inputs();
    for (int i = 1; i < 4; i++) begin
      sample();
      check_output($sformatf("to_wait%0d_rvalid", i), m0_rvalid, 0);
      check_output($sformatf("to_wait%0d_err", i), err, 0);
      next_cycle();
    end
    sample();
    check_output("to_fire_rvalid", m0_rvalid, 1);
    check_output("to_fire_m1_rvalid", m1_rvalid, 0);
    check_output("to_fire_rdata", m0_rdata, 32'hDEADBEEF);
    check_output("to_fire_err", err, 1);
    next_cycle();
    m0_req = 1; m0_write = 1; m0_addr = 12'h050; s_ready = 1;
    sample();
    check_output("to_after_err", err, 0);
    check_output("to_after_m0_ready", m0_ready, 1);
    next_cycle();
    idle_inputs();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
